// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the control unit/accumulator and the sequential ALU.
interface alu_seq_if #(
    parameter int W = 12
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] alu_out;
    logic         z_flag;
    logic         c_flag;
    logic         busy;
    logic         done;

    modport master (
        output start, op, in1, in2,
        input  alu_out, z_flag, c_flag, busy, done
    );

    modport slave (
        input  start, op, in1, in2,
        output alu_out, z_flag, c_flag, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// 12-bit sequential ALU: PASS/ADD/SUB/AND/OR/XOR in one cycle, MUL (shift-add)
// and DIV (restoring) over 12 iterations behind a start/busy/done handshake.
module alu_seq #(
    parameter int W = 12
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;
    logic           z_q, z_d;
    logic           c_q, c_d;

    logic [W:0]     add_sum, sub_diff;
    logic [W-1:0]   fast_res;
    logic           fast_c;

    // Single-cycle ops are computed straight from the bus so they register at the start edge.
    always_comb begin
        add_sum  = {1'b0, bus.in1} + {1'b0, bus.in2};
        sub_diff = {1'b0, bus.in1} - {1'b0, bus.in2};
        fast_res = bus.in1;
        fast_c   = 1'b0;
        case (bus.op)
            OP_ADD:  begin fast_res = add_sum[W-1:0];  fast_c = add_sum[W];  end
            OP_SUB:  begin fast_res = sub_diff[W-1:0]; fast_c = sub_diff[W]; end
            OP_AND:  fast_res = bus.in1 & bus.in2;
            OP_OR:   fast_res = bus.in1 | bus.in2;
            OP_XOR:  fast_res = bus.in1 ^ bus.in2;
            default: begin end
        endcase
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_sh;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] iter_next;

    // p_q holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*W-1:W]} + {1'b0, (p_q[0] ? a_q : {W{1'b0}})};
        mul_next  = {mul_sum, p_q[W-1:1]};
        div_sh    = {p_q[2*W-1:W], p_q[W-1]};
        div_ge    = div_sh >= {1'b0, b_q};
        div_rem   = div_ge ? W'(div_sh - {1'b0, b_q}) : div_sh[W-1:0];
        div_next  = {div_rem, p_q[W-2:0], div_ge};
        iter_next = (op_q == OP_MUL) ? mul_next : div_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    a_d   = bus.in1;
                    b_d   = bus.in2;
                    cnt_d = '0;
                    if (bus.op == OP_MUL || bus.op == OP_DIV) begin
                        p_d     = {{W{1'b0}}, (bus.op == OP_MUL) ? bus.in2 : bus.in1};
                        state_d = CALC;
                    end else begin
                        out_d   = fast_res;
                        z_d     = (fast_res == '0);
                        c_d     = fast_c;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                p_d   = iter_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    out_d   = iter_next[W-1:0];
                    z_d     = (iter_next[W-1:0] == '0);
                    c_d     = (op_q == OP_MUL) ? (iter_next[2*W-1:W] != '0) : (b_q == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    assign bus.alu_out = out_q;
    assign bus.z_flag  = z_q;
    assign bus.c_flag  = c_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
endmodule
